vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Generates the 640x480@60 Hz VGA raster timing that drives pong_renderer and the text/score sprite blocks. It produces pixel_x, pixel_y and video_on, plus hsync/vsync. The sync outputs are delayed by a parameterised number of pixel steps so they line up with the renderer's registered RGB path. It also provides line/frame strobes and a frame counter for game-logic pacing such as ball motion and blink timers.

Parameters:
H_VIDEO, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_VIDEO, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)
SYNC_DELAY, 2, extra pixel steps of delay on hsync/vsync relative to pixel_x/pixel_y; range 0..7

Ports:
clk_0  in  1  pixel-domain clock (25.175 MHz)
rst  in  1  synchronous reset, active-high
pix_en  in  1  pixel-step enable; all timing advances only on edges where pix_en=1
pixel_x  out  10  current horizontal position, 0..H_TOTAL-1
pixel_y  out  10  current vertical position, 0..V_TOTAL-1
video_on  out  1  high when pixel_x<H_VIDEO and pixel_y<V_VIDEO
hsync  out  1  horizontal sync, level per SYNC_POL, delayed SYNC_DELAY steps
vsync  out  1  vertical sync, level per SYNC_POL, delayed SYNC_DELAY steps
line_start  out  1  one-clk pulse when a new line (pixel_x=0) is presented
frame_start  out  1  one-clk pulse when pixel (0,0) is presented
frame_count  out  8  completed frames since reset, modulo 256

Behaviour:
- Totals: H_TOTAL = H_VIDEO+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_VIDEO+V_FP+V_SYNC+V_BP (525).
- Internal counters h_cnt and v_cnt. On each edge with pix_en=1:
  - all outputs register the decode of the current (h_cnt, v_cnt);
  - h_cnt then increments and wraps H_TOTAL-1 -> 0;
  - v_cnt increments on the h wrap and wraps V_TOTAL-1 -> 0.
- Output latency is one pix_en step after the counter value.
- Reset, on any edge with rst=1, regardless of pix_en:
  - h_cnt=0, v_cnt=0;
  - pixel_x=0, pixel_y=0, video_on=0;
  - hsync=vsync=~SYNC_POL, and every sync delay stage is loaded with ~SYNC_POL;
  - line_start=0, frame_start=0, frame_count=0.
- First enabled edge after reset presents pixel_x=0, pixel_y=0, video_on=1, line_start=1, frame_start=1, frame_count=0.
- Raw sync decodes:
  - hsync_raw is asserted for h_cnt in [H_VIDEO+H_FP, H_VIDEO+H_FP+H_SYNC-1] (656..751).
  - vsync_raw is asserted for v_cnt in [V_VIDEO+V_FP, V_VIDEO+V_FP+V_SYNC-1] (490..491), for the whole line.
- Sync delay: both raw syncs pass through a SYNC_DELAY-deep shift register that shifts only when pix_en=1. With SYNC_DELAY=0, hsync/vsync align exactly with pixel_x/pixel_y.
- Strobes:
  - line_start is set on an enabled edge presenting pixel_x=0; frame_start is set on an enabled edge presenting (0,0).
  - Both clear on the next clk edge, so the pulse is exactly one clk wide even if pix_en stays low.
- frame_count increments, with 8-bit wrap 255 -> 0, on every frame_start edge except the first after reset.
- pix_en=0: pixel_x, pixel_y, video_on, hsync, vsync and frame_count hold.
- Reset mid-frame takes effect on that edge; no partial line or frame is finished. Sync outputs go inactive immediately, not after SYNC_DELAY.
- Arithmetic: counters are 10 bits; every comparison uses parameter-derived constants; no wrap beyond H_TOTAL/V_TOTAL is possible.

Test Plan:
1. rst=1 for 3 clks, then pix_en=1 constant -> on the first enabled edge: pixel_x=0, pixel_y=0, video_on=1, line_start=1, frame_start=1, frame_count=0, hsync=1, vsync=1. line_start is low on the following clk.
2. Run one line with defaults:
   - video_on is high for exactly 640 consecutive steps and line_start repeats every 800 steps;
   - hsync goes low on the step presenting pixel_x=658 and stays low for 96 steps.
3. Run two frames:
   - vsync is low for 2 lines, starting when pixel_y=490 and pixel_x=2;
   - frame_start repeats every 420000 steps;
   - frame_count=1 at the second frame_start.
4. pix_en alternating 1,0 -> pixel_x advances on every second clk and holds otherwise; line_start/frame_start are still exactly one clk wide.
5. Assert rst for 1 clk while pixel_x=300, pixel_y=200, pix_en=1 -> next edge shows all reset values. hsync/vsync stay inactive for the first SYNC_DELAY steps after release. Frame restarts at (0,0) with frame_count=0.
6. Set SYNC_POL=1, SYNC_DELAY=0, and shrink the totals to H=8 and V=4 -> hsync is high exactly while pixel_x is in the sync window. frame_count wraps 255 -> 0 after 256 frames.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters with registered position/blanking decode,
// delayed sync outputs, line/frame strobes and a frame counter.
module vga_timing_gen #(
    parameter int   H_VIDEO    = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_VIDEO    = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter logic SYNC_POL   = 1'b0,
    parameter int   SYNC_DELAY = 2
) (
    input  logic       clk_0,
    input  logic       rst,
    input  logic       pix_en,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);
    localparam int         H_TOTAL  = H_VIDEO + H_FP + H_SYNC + H_BP;
    localparam int         V_TOTAL  = V_VIDEO + V_FP + V_SYNC + V_BP;
    localparam int         SW       = SYNC_DELAY + 1;
    localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VID    = 10'(H_VIDEO);
    localparam logic [9:0] V_VID    = 10'(V_VIDEO);
    localparam logic [9:0] HS_START = 10'(H_VIDEO + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VIDEO + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_VIDEO + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VIDEO + V_FP + V_SYNC - 1);

    logic [9:0]    r_h_cnt;
    logic [9:0]    r_v_cnt;
    logic          r_started;
    logic [SW-1:0] r_hs_sr;
    logic [SW-1:0] r_vs_sr;
    logic          w_h_end;
    logic          w_origin;
    logic          w_hs_raw;
    logic          w_vs_raw;

    assign w_h_end  = r_h_cnt == H_MAX;
    assign w_origin = r_h_cnt == 10'd0 && r_v_cnt == 10'd0;
    assign w_hs_raw = (r_h_cnt >= HS_START && r_h_cnt <= HS_END) ? SYNC_POL : ~SYNC_POL;
    assign w_vs_raw = (r_v_cnt >= VS_START && r_v_cnt <= VS_END) ? SYNC_POL : ~SYNC_POL;
    // The top stage of each shift register is the output flop, so depth 0 aligns with pixel_x.
    assign hsync    = r_hs_sr[SYNC_DELAY];
    assign vsync    = r_vs_sr[SYNC_DELAY];

    always_ff @(posedge clk_0) begin
        if (rst) begin
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            r_started   <= 1'b0;
            r_hs_sr     <= {SW{~SYNC_POL}};
            r_vs_sr     <= {SW{~SYNC_POL}};
            pixel_x     <= '0;
            pixel_y     <= '0;
            video_on    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pix_en) begin
                pixel_x     <= r_h_cnt;
                pixel_y     <= r_v_cnt;
                video_on    <= r_h_cnt < H_VID && r_v_cnt < V_VID;
                line_start  <= r_h_cnt == 10'd0;
                frame_start <= w_origin;
                r_hs_sr     <= SW'({r_hs_sr, w_hs_raw});
                r_vs_sr     <= SW'({r_vs_sr, w_vs_raw});
                r_started   <= 1'b1;
                // The very first frame after reset is not a completed frame.
                if (w_origin && r_started)
                    frame_count <= frame_count + 8'd1;
                r_h_cnt     <= w_h_end ? 10'd0 : r_h_cnt + 10'd1;
                if (w_h_end)
                    r_v_cnt <= (r_v_cnt == V_MAX) ? 10'd0 : r_v_cnt + 10'd1;
            end
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three configurations checked every clk against an
// arithmetic raster model driven by the count of enabled steps since reset.
module tb_vga_timing_gen;
    localparam int HV [3] = '{640, 16, 4};
    localparam int HF [3] = '{16, 2, 1};
    localparam int HS [3] = '{96, 4, 2};
    localparam int HB [3] = '{48, 2, 1};
    localparam int VV [3] = '{480, 6, 1};
    localparam int VF [3] = '{10, 1, 1};
    localparam int VS [3] = '{2, 2, 1};
    localparam int VB [3] = '{33, 1, 1};
    localparam int POL[3] = '{0, 0, 1};
    localparam int DL [3] = '{2, 3, 0};

    logic       clk = 1'b0;
    logic       rst_v [3];
    logic       en_v  [3];
    logic [9:0] px [3];
    logic [9:0] py [3];
    logic       von[3];
    logic       hs [3];
    logic       vs [3];
    logic       ls [3];
    logic       fs [3];
    logic [7:0] fc [3];
    int         k  [3];
    bit         le [3];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        vga_timing_gen #(
            .H_VIDEO(HV[g]), .H_FP(HF[g]), .H_SYNC(HS[g]), .H_BP(HB[g]),
            .V_VIDEO(VV[g]), .V_FP(VF[g]), .V_SYNC(VS[g]), .V_BP(VB[g]),
            .SYNC_POL(1'(POL[g])), .SYNC_DELAY(DL[g])
        ) u_dut (
            .clk_0(clk), .rst(rst_v[g]), .pix_en(en_v[g]),
            .pixel_x(px[g]), .pixel_y(py[g]), .video_on(von[g]),
            .hsync(hs[g]), .vsync(vs[g]), .line_start(ls[g]),
            .frame_start(fs[g]), .frame_count(fc[g])
        );
    end

    task automatic cmp(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d step%0d observed %0d expected %0d", tag, d, k[d], obs, exp);
        end
    endtask

    task automatic check(input int d);
        int ht, vt, p, x, y, q, xr, yr, inact;
        int ex, ey, ev, ehs, evs, els, efs, efc;
        ht    = HV[d] + HF[d] + HS[d] + HB[d];
        vt    = VV[d] + VF[d] + VS[d] + VB[d];
        inact = 1 - POL[d];
        {ex, ey, ev, els, efs, efc} = '0;
        ehs = inact;
        evs = inact;
        if (k[d] > 0) begin
            p   = k[d] - 1;
            x   = p % ht;
            y   = (p / ht) % vt;
            ex  = x;
            ey  = y;
            ev  = int'(x < HV[d] && y < VV[d]);
            els = int'(le[d] && x == 0);
            efs = int'(le[d] && x == 0 && y == 0);
            efc = (p / (ht * vt)) % 256;
            q   = p - DL[d];
            if (q >= 0) begin
                xr  = q % ht;
                yr  = (q / ht) % vt;
                ehs = (xr >= HV[d] + HF[d] && xr < HV[d] + HF[d] + HS[d]) ? POL[d] : inact;
                evs = (yr >= VV[d] + VF[d] && yr < VV[d] + VF[d] + VS[d]) ? POL[d] : inact;
            end
        end
        cmp("pixel_x", d, 32'(px[d]), ex);
        cmp("pixel_y", d, 32'(py[d]), ey);
        cmp("video_on", d, 32'(von[d]), ev);
        cmp("hsync", d, 32'(hs[d]), ehs);
        cmp("vsync", d, 32'(vs[d]), evs);
        cmp("line_start", d, 32'(ls[d]), els);
        cmp("frame_start", d, 32'(fs[d]), efs);
        cmp("frame_count", d, 32'(fc[d]), efc);
    endtask

    task automatic step(input int d, input logic r, input logic e);
        rst_v[d] = r;
        en_v[d]  = e;
        @(posedge clk);
        #1;
        if (r) begin
            k[d]  = 0;
            le[d] = 1'b0;
        end else begin
            le[d] = e;
            if (e) k[d]++;
        end
        check(d);
    endtask

    initial begin
        int vcnt, hcnt, hfall;
        bit found;
        for (int d = 0; d < 3; d++) begin
            rst_v[d] = 1'b1;
            en_v[d]  = 1'b0;
            k[d]     = 0;
            le[d]    = 1'b0;
        end
        // Default timing: reset, first edge, one full line of statistics.
        for (int i = 0; i < 3; i++) step(0, 1'b1, 1'b0);
        step(0, 1'b0, 1'b1);
        cmp("first_x", 0, 32'(px[0]), 0);
        cmp("first_fs", 0, 32'(fs[0]), 1);
        cmp("first_ls", 0, 32'(ls[0]), 1);
        cmp("first_von", 0, 32'(von[0]), 1);
        cmp("first_hs", 0, 32'(hs[0]), 1);
        cmp("first_vs", 0, 32'(vs[0]), 1);
        vcnt  = int'(von[0]);
        hcnt  = 0;
        hfall = -1;
        for (int i = 1; i < 800; i++) begin
            step(0, 1'b0, 1'b1);
            if (i == 1) cmp("ls_clear", 0, 32'(ls[0]), 0);
            vcnt += int'(von[0]);
            if (hs[0] == 1'b0) begin
                hcnt++;
                if (hfall < 0) hfall = int'(px[0]);
            end
        end
        cmp("von_run", 0, vcnt, 640);
        cmp("hs_low_len", 0, hcnt, 96);
        cmp("hs_fall_x", 0, hfall, 658);
        step(0, 1'b0, 1'b1);
        cmp("ls_period", 0, 32'(ls[0]), 1);
        cmp("line1_y", 0, 32'(py[0]), 1);
        for (int i = 0; i < 40; i++) step(0, 1'b0, i % 2 == 0);
        for (int i = 0; i < 400; i++) step(0, 1'b0, $urandom_range(0, 2) != 0);
        // Mid-line reset once pixel_x reaches 300.
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            step(0, 1'b0, 1'b1);
            found = px[0] == 10'd300;
        end
        cmp("reach_x300", 0, 32'(found), 1);
        step(0, 1'b1, 1'b1);
        cmp("rst_x", 0, 32'(px[0]), 0);
        cmp("rst_hs", 0, 32'(hs[0]), 1);
        for (int i = 0; i < 20; i++) step(0, 1'b0, 1'b1);
        // Small raster, delay 3: vsync and frame counting over several frames.
        for (int i = 0; i < 2; i++) step(1, 1'b1, 1'b0);
        for (int i = 0; i < 1000; i++) step(1, 1'b0, $urandom_range(0, 3) != 0);
        step(1, 1'b1, 1'b1);
        for (int i = 0; i < 300; i++) step(1, $urandom_range(0, 150) == 0, $urandom_range(0, 1) != 0);
        // Tiny raster, active-high sync, no delay: frame_count wrap.
        step(2, 1'b1, 1'b0);
        for (int i = 0; i < 256 * 32; i++) step(2, 1'b0, 1'b1);
        cmp("fc_pre_wrap", 2, 32'(fc[2]), 255);
        step(2, 1'b0, 1'b1);
        cmp("fc_wrap", 2, 32'(fc[2]), 0);
        cmp("fs_wrap", 2, 32'(fs[2]), 1);
        for (int i = 0; i < 100; i++) step(2, 1'b0, $urandom_range(0, 1) != 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
